// File: rtl/pc_fetch_unit_if.sv
// Instruction-fetch bus: imem request/response plus the instr hand-off to decode.
// master = fetch unit, slave = imem + downstream consumer.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_rdata, imem_ready, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_rdata, imem_ready, instr_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and single-outstanding instruction fetch.
// Optional macro FETCH_TIMEOUT_EN adds an imem wait-cycle limit (TIMEOUT_CYCLES)
// that raises the sticky fetch_timeout flag and parks the block in ERR.
//
// state | meaning
// IDLE  | just out of reset, first request issued on the next edge
// FETCH | imem_req high at imem_addr=pc, waiting for imem_ready
// HOLD  | instr_valid high, waiting for the consumer to take instr
// ERR   | misaligned npc or imem timeout; parked until reset
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     npc,
  output logic [31:0]     pc,
  pc_fetch_unit_if.master bus,
  output logic            misalign,
  output logic            fetch_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        npc_aligned;
  logic        tmo_hit;

  assign npc_aligned = (npc[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = TIMEOUT_CYCLES[7:0];

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_inc;
  logic       timeout_q, timeout_d;

  // Saturating wait count; the limit fires on the cycle the count would reach it.
  assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
  assign tmo_hit  = (state_q == FETCH) && !bus.imem_ready && (wait_inc == TMO_LIMIT);
`else
  assign tmo_hit  = 1'b0;
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; imem_ready wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH: begin
        if (bus.imem_ready) state_d = HOLD;
        else if (tmo_hit)   state_d = ERR;
      end
      HOLD: begin
        if (bus.instr_ready) state_d = npc_aligned ? FETCH : ERR;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    pc_d       = pc_q;
    req_d      = req_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = 8'd0;
`endif
      end
      FETCH: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          wait_cnt_d = wait_inc;
          if (tmo_hit) begin
            timeout_d = 1'b1;
            req_d     = 1'b0;
          end
        end
`endif
      end
      HOLD: begin
        if (bus.instr_ready) begin
          // Misaligned npc is still loaded so it is visible for debug.
          pc_d    = npc;
          valid_d = 1'b0;
          if (npc_aligned) begin
            req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_d = 8'd0;
`endif
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign fetch_timeout = timeout_q;
`else
  // No timeout logic in this build; the limit only matters with the feature on.
  assign fetch_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  assign pc              = pc_q;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign misalign        = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit; inputs change and outputs are sampled on negedge.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        misalign;
  logic        fetch_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .npc           (npc),
    .pc            (pc),
    .bus           (bus.master),
    .misalign      (misalign),
    .fetch_timeout (fetch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstn           = 1'b0;
    npc            = 32'h0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    step();

    // Reset state
    check("rst_pc", pc, 32'h0);
    check("rst_req", bus.imem_req, 32'h0);
    check("rst_valid", bus.instr_valid, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_misalign", misalign, 32'h0);
    check("rst_timeout", fetch_timeout, 32'h0);

    // Zero-wait imem, always-ready consumer
    rstn            = 1'b1;
    bus.imem_ready  = 1'b1;
    bus.instr_ready = 1'b1;
    bus.imem_rdata  = 32'hA000_0000;
    step();
    check("t1_first_req", bus.imem_req, 32'h1);
    check("t1_addr0", bus.imem_addr, 32'h0);
    check("t1_valid0", bus.instr_valid, 32'h0);
    step();
    check("t1_valid_hi", bus.instr_valid, 32'h1);
    check("t1_instr0", bus.instr, 32'hA000_0000);
    check("t1_pc0", pc, 32'h0);
    check("t1_req_lo", bus.imem_req, 32'h0);
    npc = 32'h4;
    step();
    check("t1_addr4", bus.imem_addr, 32'h4);
    check("t1_req4", bus.imem_req, 32'h1);
    check("t1_valid_lo", bus.instr_valid, 32'h0);
    bus.imem_rdata = 32'hA000_0004;
    step();
    check("t1_valid4", bus.instr_valid, 32'h1);
    check("t1_instr4", bus.instr, 32'hA000_0004);
    npc = 32'h8;
    step();
    check("t1_addr8", bus.imem_addr, 32'h8);
    check("t1_req8", bus.imem_req, 32'h1);

    // imem_ready delayed 5 cycles at pc=0x8
    bus.imem_ready  = 1'b0;
    bus.instr_ready = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_req_hold", bus.imem_req, 32'h1);
      check("t2_addr_hold", bus.imem_addr, 32'h8);
      check("t2_valid_lo", bus.instr_valid, 32'h0);
      check("t2_pc_hold", pc, 32'h8);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hC0DE_0008;
    step();
    check("t2_valid", bus.instr_valid, 32'h1);
    check("t2_instr", bus.instr, 32'hC0DE_0008);
    check("t2_pc", pc, 32'h8);
    check("t2_req_lo", bus.imem_req, 32'h0);

    // Consumer stalls in HOLD while imem_ready toggles
    for (int i = 0; i < 4; i++) begin
      bus.imem_ready = i[0];
      bus.imem_rdata = 32'h1111_1111;
      npc            = 32'h40;
      step();
      check("t3_valid_hold", bus.instr_valid, 32'h1);
      check("t3_instr_hold", bus.instr, 32'hC0DE_0008);
      check("t3_pc_hold", pc, 32'h8);
      check("t3_no_req", bus.imem_req, 32'h0);
    end
    bus.instr_ready = 1'b1;
    bus.imem_ready  = 1'b0;
    step();
    check("t3_addr40", bus.imem_addr, 32'h40);
    check("t3_req40", bus.imem_req, 32'h1);
    check("t3_valid_lo", bus.instr_valid, 32'h0);

    // npc loaded verbatim: 0xFFFF_FFFC then 0
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    npc            = 32'hFFFF_FFFC;
    step();
    check("t4_valid", bus.instr_valid, 32'h1);
    check("t4_instr", bus.instr, 32'h1234_5678);
    step();
    check("t4_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    check("t4_req_top", bus.imem_req, 32'h1);
    bus.imem_rdata = 32'h55AA_55AA;
    npc            = 32'h0;
    step();
    check("t4_instr_top", bus.instr, 32'h55AA_55AA);
    step();
    check("t4_pc_wrap", pc, 32'h0);
    check("t4_req_wrap", bus.imem_req, 32'h1);

    // Misaligned npc -> ERR
    npc            = 32'h0000_0042;
    bus.imem_rdata = 32'h0000_0066;
    step();
    check("t5_valid", bus.instr_valid, 32'h1);
    check("t5_misalign_pre", misalign, 32'h0);
    step();
    check("t5_misalign", misalign, 32'h1);
    check("t5_pc42", pc, 32'h42);
    check("t5_req_lo", bus.imem_req, 32'h0);
    check("t5_valid_lo", bus.instr_valid, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_err_req", bus.imem_req, 32'h0);
      check("t5_err_valid", bus.instr_valid, 32'h0);
      check("t5_err_flag", misalign, 32'h1);
      check("t5_err_pc", pc, 32'h42);
      check("t5_err_tmo", fetch_timeout, 32'h0);
    end
    rstn = 1'b0;
    step();
    check("t5_rst_pc", pc, 32'h0);
    check("t5_rst_req", bus.imem_req, 32'h0);
    check("t5_rst_valid", bus.instr_valid, 32'h0);
    check("t5_rst_instr", bus.instr, 32'h0);
    check("t5_rst_misalign", misalign, 32'h0);
    rstn           = 1'b1;
    bus.imem_ready = 1'b0;
    step();
    check("t5_restart_req", bus.imem_req, 32'h1);
    check("t5_restart_addr", bus.imem_addr, 32'h0);

    // Reset during FETCH with imem_ready in the same cycle
    rstn           = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hFFFF_0000;
    step();
    check("t6_valid", bus.instr_valid, 32'h0);
    check("t6_instr", bus.instr, 32'h0);
    check("t6_req", bus.imem_req, 32'h0);
    rstn           = 1'b1;
    bus.imem_ready = 1'b0;
    step();
    check("t6_req_after", bus.imem_req, 32'h1);
    check("t6_addr_after", bus.imem_addr, 32'h0);
    check("t6_valid_after", bus.instr_valid, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // 16 FETCH cycles without ready -> timeout
    for (int i = 0; i < 15; i++) begin
      step();
      check("t7_req_wait", bus.imem_req, 32'h1);
      check("t7_tmo_lo", fetch_timeout, 32'h0);
    end
    step();
    check("t7_tmo_hi", fetch_timeout, 32'h1);
    check("t7_req_lo", bus.imem_req, 32'h0);
    bus.imem_ready = 1'b1;
    step();
    check("t7_err_valid", bus.instr_valid, 32'h0);
    check("t7_err_tmo", fetch_timeout, 32'h1);
    rstn           = 1'b0;
    bus.imem_ready = 1'b0;
    step();
    check("t7_rst_tmo", fetch_timeout, 32'h0);
    rstn = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      step();
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0000_0077;
    step();
    check("t7_edge_valid", bus.instr_valid, 32'h1);
    check("t7_edge_instr", bus.instr, 32'h0000_0077);
    check("t7_edge_tmo", fetch_timeout, 32'h0);
`else
    // Without the timeout feature FETCH waits indefinitely
    for (int i = 0; i < 30; i++) begin
      step();
    end
    check("t7_req_wait", bus.imem_req, 32'h1);
    check("t7_addr_wait", bus.imem_addr, 32'h0);
    check("t7_valid_wait", bus.instr_valid, 32'h0);
    check("t7_tmo_tied", fetch_timeout, 32'h0);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0000_0077;
    step();
    check("t7_late_valid", bus.instr_valid, 32'h1);
    check("t7_late_instr", bus.instr, 32'h0000_0077);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
